// File: rtl/rt_mod_sched.sv
// Round-robin scheduler and one-entry result cache in front of the shared
// Montgomery precompute engine (R mod n / R^2 mod n).
module rt_mod_sched #(
  parameter int W    = 4096,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0] req_n,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_r,
  input  logic              cache_flush,
  output logic              busy,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic              eng_go,
  output logic              eng_mode,
  output logic [W-1:0]      eng_n,
  input  logic [W-1:0]      eng_r,
  input  logic              eng_done
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_GO, S_GUARD, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, id_q, id_d;
  logic [W-1:0]      n_q, n_d;
  logic              op_q, op_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d, rsp_valid_q, rsp_valid_d;
  logic [W-1:0]      rsp_r_q, rsp_r_d;
  logic              busy_q, busy_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic              eng_go_q, eng_go_d, eng_mode_q, eng_mode_d;
  logic [W-1:0]      eng_n_q, eng_n_d;
  logic              vr_q, vr_d, vr2_q, vr2_d;
  logic [W-1:0]      cn_q, cn_d, cr_q, cr_d, cr2_q, cr2_d;

  logic              found, hit, fill;
  logic [IW-1:0]     cand, gnt;

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    n_d         = n_q;
    op_d        = op_q;
    req_ack_d   = '0;
    rsp_valid_d = '0;
    rsp_r_d     = rsp_r_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    eng_go_d    = 1'b0;
    eng_mode_d  = eng_mode_q;
    eng_n_d     = eng_n_q;
    vr_d        = vr_q & ~cache_flush;
    vr2_d       = vr2_q & ~cache_flush;
    cn_d        = cn_q;
    cr_d        = cr_q;
    cr2_d       = cr2_q;
    fill        = 1'b0;
    found       = 1'b0;
    gnt         = ptr_q;
    cand        = '0;

    // First requester after the pointer, wrapping.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end

    // A flush on the LOOKUP edge takes effect before the compare.
    hit = !cache_flush && (n_q == cn_q) && (op_q ? vr2_q : vr_q);

    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d           = gnt;
          ptr_d          = gnt;
          n_d            = req_n[gnt*W +: W];
          op_d           = req_op[gnt];
          req_ack_d[gnt] = 1'b1;
          state_d        = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          rsp_r_d            = op_q ? cr2_q : cr_q;
          rsp_valid_d[id_q]  = 1'b1;
          hit_cnt_d          = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
          state_d            = S_IDLE;
        end else begin
          eng_n_d    = n_q;
          eng_mode_d = op_q;
          eng_go_d   = 1'b1;
          miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
          state_d    = S_GO;
        end
      end
      S_GO:    state_d = S_GUARD;
      // eng_done may still be high from the previous run here.
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          rsp_r_d           = eng_r;
          rsp_valid_d[id_q] = 1'b1;
          fill              = 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fill) begin
      if (n_q != cn_q) begin
        cn_d  = n_q;
        vr_d  = 1'b0;
        vr2_d = 1'b0;
      end
      if (op_q) begin
        vr2_d = 1'b1;
        cr2_d = eng_r;
      end else begin
        vr_d = 1'b1;
        cr_d = eng_r;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IW'(NREQ - 1);
      id_q        <= '0;
      n_q         <= '0;
      op_q        <= 1'b0;
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
      rsp_r_q     <= '0;
      busy_q      <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      eng_go_q    <= 1'b0;
      eng_mode_q  <= 1'b0;
      eng_n_q     <= '0;
      vr_q        <= 1'b0;
      vr2_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      n_q         <= n_d;
      op_q        <= op_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      busy_q      <= busy_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      eng_go_q    <= eng_go_d;
      eng_mode_q  <= eng_mode_d;
      eng_n_q     <= eng_n_d;
      vr_q        <= vr_d;
      vr2_q       <= vr2_d;
    end
  end

  // NOTE: cache tag/data are qualified by vr/vr2, so they carry no reset.
  always_ff @(posedge clk) begin
    cn_q  <= cn_d;
    cr_q  <= cr_d;
    cr2_q <= cr2_d;
  end

  assign req_ack   = req_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign busy      = busy_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign eng_go    = eng_go_q;
  assign eng_mode  = eng_mode_q;
  assign eng_n     = eng_n_q;
endmodule

// File: tb/tb_rt_mod_sched.sv
// Bench for rt_mod_sched: W=8 behavioural engine with a sluggish, never-reset
// done flag, plus an arithmetic cache/arbitration model.
module tb_rt_mod_sched;
  localparam int W    = 8;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_op = '0;
  logic [NREQ*W-1:0] req_n = '0;
  logic [NREQ-1:0]   req_ack, rsp_valid;
  logic [W-1:0]      rsp_r;
  logic              cache_flush = 1'b0;
  logic              busy;
  logic [15:0]       hit_cnt, miss_cnt;
  logic              eng_go, eng_mode;
  logic [W-1:0]      eng_n;
  logic [W-1:0]      eng_r = '0;
  logic              eng_done;

  rt_mod_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_n(req_n),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_r(rsp_r), .cache_flush(cache_flush),
    .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .eng_go(eng_go),
    .eng_mode(eng_mode), .eng_n(eng_n), .eng_r(eng_r), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // R = 2^W; result is R mod n or R^2 mod n.
  function automatic logic [W-1:0] rmod(input int n, input bit op);
    if (n == 0) return '0;
    return op ? W'((1 << (2 * W)) % n) : W'((1 << W) % n);
  endfunction

  // Engine: sees go one edge late, so a stale done lingers into GUARD.
  logic eng_done_q = 1'b0;
  logic force_done = 1'b0;
  logic go_seen = 1'b0;
  logic e_run = 1'b0;
  int   e_cnt = 0;
  int   e_lat = 2;
  assign eng_done = eng_done_q | force_done;

  always @(posedge clk) begin
    go_seen <= eng_go;
    if (go_seen) begin
      e_run      <= 1'b1;
      e_cnt      <= e_lat;
      eng_done_q <= 1'b0;
    end else if (e_run) begin
      if (e_cnt == 0) begin
        e_run      <= 1'b0;
        eng_done_q <= 1'b1;
        eng_r      <= rmod(int'(eng_n), eng_mode);
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end
  end

  // Reference model: one tagged entry, two valid bits, RR pointer, counters.
  int           m_cn = -1;
  bit           m_vr [2];
  int           m_hits = 0;
  int           m_miss = 0;
  int           m_ptr = NREQ - 1;
  logic [W-1:0] last_r = '0;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic bit m_hit(input int n, input bit op);
    return (n == m_cn) && m_vr[op];
  endfunction

  task automatic m_fill(input int n, input bit op);
    if (n != m_cn) begin
      m_cn = n;
      m_vr[0] = 1'b0;
      m_vr[1] = 1'b0;
    end
    m_vr[op] = 1'b1;
  endtask

  task automatic m_reset();
    m_cn = -1; m_vr[0] = 1'b0; m_vr[1] = 1'b0;
    m_hits = 0; m_miss = 0; m_ptr = NREQ - 1; last_r = '0;
  endtask

  // One request from requester id, optionally flushing on its LOOKUP edge.
  task automatic do_req(input int id, input int n, input bit op, input bit flush);
    int cyc, gos;
    bit got, hit;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_op[id] = op;
    req_n[id*W +: W] = W'(n);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ack != 0) got = 1'b1;
    end
    check("ack_seen", got, 1);
    if (!got) begin
      req_valid[id] = 1'b0;
      return;
    end
    check("ack_id", req_ack, 64'(1 << id));
    check("busy_lookup", busy, 1);
    req_valid[id] = 1'b0;
    m_ptr = id;
    if (flush) begin
      cache_flush = 1'b1;
      m_vr[0] = 1'b0;
      m_vr[1] = 1'b0;
    end
    hit = m_hit(n, op);
    if (hit) m_hits++; else m_miss++;
    cyc = 0; gos = 0; got = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cache_flush = 1'b0;
      cyc++;
      if (eng_go) gos++;
      if (rsp_valid != 0) got = 1'b1;
      else check("rsp_hold", rsp_r, last_r);
    end
    check("rsp_seen", got, 1);
    if (!got) return;
    check("rsp_id", rsp_valid, 64'(1 << id));
    check("rsp_r", rsp_r, rmod(n, op));
    check("go_pulses", gos, hit ? 0 : 1);
    if (hit) check("hit_latency", cyc, 1);
    else begin
      check("eng_mode", eng_mode, op);
      check("eng_n", eng_n, n);
      m_fill(n, op);
    end
    check("busy_idle", busy, 0);
    check("hit_cnt", hit_cnt, sat(m_hits));
    check("miss_cnt", miss_cnt, sat(m_miss));
    last_r = rmod(n, op);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int pool [6] = '{13, 11, 200, 97, 255, 2};

  initial begin
    int spur, acks, pend, exp_id, cyc;
    bit pend_v, hit;
    int an [2];
    bit ao [2];

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ack", req_ack, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_r", rsp_r, 0);
    check("rst_busy", busy, 0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 0);
    check("rst_eng", {eng_go, eng_mode, eng_n}, 0);
    rst = 1'b0;

    // Stale done during IDLE must not produce a response.
    force_done = 1'b1;
    spur = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid != 0 || busy) spur++;
    end
    force_done = 1'b0;
    check("idle_stale_done", spur, 0);

    // Directed sequence from the test plan.
    do_req(0, 13, 1'b0, 1'b0);
    do_req(0, 13, 1'b0, 1'b0);
    check("tp_hit_cnt", hit_cnt, 1);
    check("tp_miss_cnt", miss_cnt, 1);
    do_req(1, 13, 1'b1, 1'b0);
    do_req(1, 11, 1'b0, 1'b0);
    do_req(1, 13, 1'b1, 1'b0);
    do_req(0, 13, 1'b1, 1'b1);

    // Both requesters held valid: grants must alternate.
    an[0] = 13; ao[0] = 1'b0; an[1] = 13; ao[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = ao[i];
      req_n[i*W +: W] = W'(an[i]);
    end
    req_valid = '1;
    acks = 0; pend_v = 1'b0; pend = 0; cyc = 0;
    while (cyc < 400 && (acks < 6 || pend_v)) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != 0) begin
        check("alt_rsp_pending", pend_v, 1);
        check("alt_rsp_id", rsp_valid, 64'(1 << pend));
        check("alt_rsp_r", rsp_r, rmod(an[pend], ao[pend]));
        last_r = rmod(an[pend], ao[pend]);
        pend_v = 1'b0;
      end
      if (req_ack != 0) begin
        exp_id = (m_ptr + 1) % NREQ;
        check("alt_grant", req_ack, 64'(1 << exp_id));
        check("alt_no_overlap", pend_v, 0);
        m_ptr = exp_id;
        pend = exp_id;
        pend_v = 1'b1;
        acks++;
        hit = m_hit(an[pend], ao[pend]);
        if (hit) m_hits++;
        else begin
          m_miss++;
          m_fill(an[pend], ao[pend]);
        end
        if (acks == 6) req_valid = '0;
      end
    end
    req_valid = '0;
    check("alt_done", acks, 6);
    check("alt_hit_cnt", hit_cnt, sat(m_hits));
    check("alt_miss_cnt", miss_cnt, sat(m_miss));

    // Asynchronous reset in WAIT, with a slow engine still running afterwards.
    e_lat = 20;
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 1'b1; req_n[0 +: W] = W'(77);
    cyc = 0;
    while (cyc < 20 && req_ack == 0) begin
      @(negedge clk);
      cyc++;
    end
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("wait_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_outs", {req_ack, rsp_valid, rsp_r, eng_go, eng_mode, eng_n}, 0);
    check("arst_cnts", {hit_cnt, miss_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    spur = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid != 0) spur++;
    end
    check("post_rst_no_rsp", spur, 0);
    e_lat = 3;
    do_req(0, 13, 1'b1, 1'b0);
    do_req(1, 13, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      e_lat = $urandom_range(0, 5);
      do_req($urandom_range(0, 1), pool[$urandom_range(0, 5)],
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
